// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if: request/value/display bundle between two requesters and the arbiter.
interface hex_display_arbiter_if;
  logic [1:0]  req;
  logic [15:0] value0;
  logic [15:0] value1;
  logic [1:0]  grant;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic        busy;
  modport master (output req, value0, value1, input grant, hex0, hex1, hex2, hex3, busy);
  modport slave  (input req, value0, value1, output grant, hex0, hex1, hex2, hex3, busy);
endinterface

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: two-requester round-robin owner of a 4-digit hex display with minimum hold time.
// Optional leading-zero blanking via HEX_LEADING_ZERO_BLANK_EN.
module hex_display_arbiter #(
  parameter logic [23:0] TICK_DIV   = 24'd12_000_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  hex_display_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;
  localparam logic [7:0] HOLD = 8'(HOLD_TICKS);
  state_t      state_q, state_d;
  logic [23:0] tick_q, tick_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic [15:0] disp_q, disp_d;
  logic        tick, expired, own, other, pick;
  logic [2:0]  blank;
  assign tick    = tick_q == TICK_DIV - 24'd1;
  assign tick_d  = tick ? '0 : tick_q + 24'd1;
  assign expired = hold_q == HOLD;
  assign own     = grant_q[1];
  assign other   = ~own;
  assign pick    = (&bus.req) ? ptr_q : bus.req[1];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    disp_d  = disp_q;
    hold_d  = (tick && hold_q != HOLD) ? hold_q + 8'd1 : hold_q;
    if (state_q == IDLE) begin
      hold_d = '0;
      if (|bus.req) begin
        state_d = SHOW;
        grant_d = pick ? 2'b10 : 2'b01;
        ptr_d   = ~pick;
        disp_d  = pick ? bus.value1 : bus.value0;
      end
    end else if (expired) begin
      // expiry wins over a coincident tick: hold restarts from zero
      hold_d = '0;
      if (bus.req[other]) begin
        state_d = SHOW;
        grant_d = ~grant_q;
        ptr_d   = own;
        disp_d  = other ? bus.value1 : bus.value0;
      end else if (bus.req[own]) begin
        state_d = SHOW;
        disp_d  = own ? bus.value1 : bus.value0;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end else if (state_q == SHOW) begin
      disp_d  = own ? bus.value1 : bus.value0;
      state_d = bus.req[own] ? SHOW : LINGER;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      ptr_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      disp_q  <= disp_d;
    end
  end
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction
`ifdef HEX_LEADING_ZERO_BLANK_EN
  assign blank = {disp_q[15:12] == 4'h0, disp_q[15:8] == 8'h00, disp_q[15:4] == 12'h000};
`else
  assign blank = '0;
`endif
  assign bus.hex3  = (state_q == IDLE || blank[2]) ? 7'h7F : seg(disp_q[15:12]);
  assign bus.hex2  = (state_q == IDLE || blank[1]) ? 7'h7F : seg(disp_q[11:8]);
  assign bus.hex1  = (state_q == IDLE || blank[0]) ? 7'h7F : seg(disp_q[7:4]);
  assign bus.hex0  = (state_q == IDLE) ? 7'h7F : seg(disp_q[3:0]);
  assign bus.grant = grant_q;
  assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed checks of arbitration, hold, linger, reset and digit decode.
module tb_hex_display_arbiter;
  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;
  logic [27:0] hexall;
  localparam logic [27:0] BLANK = {4{7'h7F}};
  localparam logic [27:0] H1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] HABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
`ifdef HEX_LEADING_ZERO_BLANK_EN
  localparam logic [27:0] H0050 = {7'h7F, 7'h7F, 7'b0010010, 7'b1000000};
  localparam logic [27:0] H0000 = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
`else
  localparam logic [27:0] H0050 = {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000};
  localparam logic [27:0] H0000 = {4{7'b1000000}};
`endif
  hex_display_arbiter_if bus();
  hex_display_arbiter #(.TICK_DIV(24'd4), .HOLD_TICKS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign hexall = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // n counts edges since the current grant; expiry edge must land 6..9 edges after it
  task automatic wait_change(input logic [1:0] from, input int start, input string tag);
    int n;
    n = start;
    while (bus.grant === from && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n >= 6 && n <= 9), 32'd1);
  endtask
  task automatic start(input logic [1:0] r, input logic [15:0] v0, input logic [15:0] v1);
    rst_n = 1'b0;
    @(negedge clk);
    bus.req    = r;
    bus.value0 = v0;
    bus.value1 = v1;
    rst_n      = 1'b1;
    @(negedge clk);
  endtask
  always @(negedge clk) if (rst_n) check("onehot", 32'(&bus.grant), 32'd0);
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.req    = 2'b00;
    bus.value0 = 16'h0;
    bus.value1 = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hex", 32'(hexall), 32'(BLANK));
    start(2'b01, 16'h1234, 16'h0);
    check("grant0", 32'(bus.grant), 32'h1);
    check("busy", 32'(bus.busy), 32'd1);
    check("hex1234", 32'(hexall), 32'(H1234));
    bus.req = 2'b00;
    @(negedge clk);
    check("linger_grant", 32'(bus.grant), 32'h1);
    bus.value0 = 16'hFFFF;
    @(negedge clk);
    check("linger_frozen", 32'(hexall), 32'(H1234));
    check("linger_busy", 32'(bus.busy), 32'd1);
    wait_change(2'b01, 2, "linger_expiry");
    check("idle_grant", 32'(bus.grant), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_hex", 32'(hexall), 32'(BLANK));
    start(2'b11, 16'h1234, 16'hABCD);
    check("rr_first", 32'(bus.grant), 32'h1);
    wait_change(2'b01, 0, "rr_hold0");
    check("rr_switch", 32'(bus.grant), 32'h2);
    check("rr_hexABCD", 32'(hexall), 32'(HABCD));
    wait_change(2'b10, 0, "rr_hold1");
    check("rr_back", 32'(bus.grant), 32'h1);
    check("rr_hex1234", 32'(hexall), 32'(H1234));
    start(2'b01, 16'h1234, 16'hABCD);
    check("np_grant", 32'(bus.grant), 32'h1);
    @(negedge clk);
    bus.req = 2'b11;
    @(negedge clk);
    check("np_hold_a", 32'(bus.grant), 32'h1);
    repeat (2) @(negedge clk);
    check("np_hold_b", 32'(bus.grant), 32'h1);
    wait_change(2'b01, 4, "np_expiry");
    check("np_single_edge", 32'(bus.grant), 32'h2);
    start(2'b01, 16'h1234, 16'hABCD);
    @(negedge clk);
    check("ar_pre", 32'(bus.grant), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(bus.grant), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_hex", 32'(hexall), 32'(BLANK));
    bus.req = 2'b11;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_ptr", 32'(bus.grant), 32'h1);
    start(2'b01, 16'h0050, 16'h0);
    check("lz_0050", 32'(hexall), 32'(H0050));
    bus.value0 = 16'h0000;
    @(negedge clk);
    check("lz_0000", 32'(hexall), 32'(H0000));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
